// File: rtl/l1_cache_pkg.sv
// l1_cache_pkg: shared L1 cache types and default geometry
package l1_cache_pkg;
    typedef enum logic [1:0] {IDLE, PROBE, SCAN, RESP} lookup_state_e;
    localparam int L1_NUM_SETS = 64;
    localparam int L1_NUM_WAYS = 4;
    localparam int L1_TAG_BITS = 20;
endpackage

// File: rtl/way_tag_compare.sv
// way_tag_compare: parallel tag compare over all ways, lowest matching way wins
// ports: tags/valid (one per way), tag (compare value) -> hit, way (0 when no hit)
module way_tag_compare #(
    parameter int NUM_WAYS = 4,
    parameter int TAG_BITS = 20,
    parameter int WAY_BITS = 2
) (
    input  logic [NUM_WAYS-1:0][TAG_BITS-1:0] tags,
    input  logic [NUM_WAYS-1:0]               valid,
    input  logic [TAG_BITS-1:0]               tag,
    output logic                              hit,
    output logic [WAY_BITS-1:0]               way
);
    // descending scan so the lowest matching way is the last write
    always_comb begin
        hit = 1'b0;
        way = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (valid[i] && tags[i] == tag) begin
                hit = 1'b1;
                way = WAY_BITS'(i);
            end
        end
    end
endmodule

// File: rtl/l1_way_lookup.sv
// l1_way_lookup: predicted-way-first L1 tag lookup with full-scan fallback
// ports: req_* lookup request, pred_* way predictor query, upd_* predictor update,
//        resp_* lookup response, fill_* tag/valid write from the refill path
module l1_way_lookup
    import l1_cache_pkg::*;
#(
    parameter int NUM_SETS   = L1_NUM_SETS,
    parameter int NUM_WAYS   = L1_NUM_WAYS,
    parameter int TAG_BITS   = L1_TAG_BITS,
    parameter int INDEX_BITS = $clog2(NUM_SETS),
    parameter int WAY_BITS   = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [INDEX_BITS-1:0] req_index,
    input  logic [TAG_BITS-1:0]   req_tag,
    output logic [INDEX_BITS-1:0] pred_index,
    input  logic [WAY_BITS-1:0]   pred_way,
    output logic                  upd_en,
    output logic [INDEX_BITS-1:0] upd_index,
    output logic [WAY_BITS-1:0]   upd_way,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_hit,
    output logic [WAY_BITS-1:0]   resp_way,
    output logic                  resp_first,
    input  logic                  fill_en,
    input  logic [INDEX_BITS-1:0] fill_index,
    input  logic [WAY_BITS-1:0]   fill_way,
    input  logic [TAG_BITS-1:0]   fill_tag,
    input  logic                  fill_valid
);
    logic [NUM_SETS-1:0][NUM_WAYS-1:0][TAG_BITS-1:0] tags_q;
    logic [NUM_SETS-1:0][NUM_WAYS-1:0]               valids_q;
    lookup_state_e state_q, state_d;
    logic [INDEX_BITS-1:0] idx_q, idx_d, upd_index_q, upd_index_d;
    logic [TAG_BITS-1:0]   rtag_q, rtag_d;
    logic [WAY_BITS-1:0]   pw_q, pw_d, resp_way_q, resp_way_d, upd_way_q, upd_way_d;
    logic resp_hit_q, resp_hit_d, resp_first_q, resp_first_d, upd_en_q, upd_en_d;
    logic probe_hit, scan_hit;
    logic [WAY_BITS-1:0] scan_way;

    // tags need no reset: an entry is only meaningful once its valid bit is set
    always_ff @(posedge clk) begin
        if (fill_en) tags_q[fill_index][fill_way] <= fill_tag;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) valids_q <= '0;
        else if (fill_en) valids_q[fill_index][fill_way] <= fill_valid;
    end

    // compares read the flops, so a same-cycle fill is seen only afterwards
    assign probe_hit = valids_q[idx_q][pw_q] && tags_q[idx_q][pw_q] == rtag_q;

    way_tag_compare #(
        .NUM_WAYS(NUM_WAYS),
        .TAG_BITS(TAG_BITS),
        .WAY_BITS(WAY_BITS)
    ) u_cmp (
        .tags (tags_q[idx_q]),
        .valid(valids_q[idx_q]),
        .tag  (rtag_q),
        .hit  (scan_hit),
        .way  (scan_way)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        rtag_d       = rtag_q;
        pw_d         = pw_q;
        resp_hit_d   = resp_hit_q;
        resp_way_d   = resp_way_q;
        resp_first_d = resp_first_q;
        upd_en_d     = 1'b0;
        upd_index_d  = upd_index_q;
        upd_way_d    = upd_way_q;
        unique case (state_q)
            IDLE: if (req_valid) begin
                idx_d   = req_index;
                rtag_d  = req_tag;
                pw_d    = pred_way;
                state_d = PROBE;
            end
            PROBE: if (probe_hit) begin
                resp_hit_d   = 1'b1;
                resp_way_d   = pw_q;
                resp_first_d = 1'b1;
                state_d      = RESP;
            end else begin
                state_d = SCAN;
            end
            SCAN: begin
                resp_hit_d   = scan_hit;
                resp_way_d   = scan_hit ? scan_way : '0;
                resp_first_d = 1'b0;
                upd_en_d     = scan_hit;
                upd_index_d  = scan_hit ? idx_q : upd_index_q;
                upd_way_d    = scan_hit ? scan_way : upd_way_q;
                state_d      = RESP;
            end
            RESP: if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            rtag_q       <= '0;
            pw_q         <= '0;
            resp_hit_q   <= 1'b0;
            resp_way_q   <= '0;
            resp_first_q <= 1'b0;
            upd_en_q     <= 1'b0;
            upd_index_q  <= '0;
            upd_way_q    <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            rtag_q       <= rtag_d;
            pw_q         <= pw_d;
            resp_hit_q   <= resp_hit_d;
            resp_way_q   <= resp_way_d;
            resp_first_q <= resp_first_d;
            upd_en_q     <= upd_en_d;
            upd_index_q  <= upd_index_d;
            upd_way_q    <= upd_way_d;
        end
    end

    assign req_ready  = state_q == IDLE && !rst;
    assign pred_index = state_q == IDLE ? req_index : idx_q;
    assign resp_valid = state_q == RESP;
    assign resp_hit   = resp_hit_q;
    assign resp_way   = resp_way_q;
    assign resp_first = resp_first_q;
    assign upd_en     = upd_en_q;
    assign upd_index  = upd_index_q;
    assign upd_way    = upd_way_q;
endmodule
